// File: rtl/vram_pkg.sv
// Shared types and defaults for the frame-buffer arbiter slice.
package vram_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_VGA, ARB_CPU} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU} owner_t;

endpackage

// File: rtl/vram_arbiter_rd_pipe.sv
// Owner-tag delay line: the tag of each accepted read emerges at the head
// on the same cycle the RAM presents its data.
module arb_rd_pipe
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t own_in,
  output owner_t own_out
);

  owner_t stage_q [DEPTH];
  owner_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = own_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign own_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: VGA has fixed priority, the CPU is
// guaranteed a grant after MAX_WAIT consecutive denials.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   SW      = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MAX_CNT = SW'(MAX_WAIT);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          forced;
  owner_t        own_issue, own_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ARB_IDLE;
    if (vga_gnt)      state_d = ARB_VGA;
    else if (cpu_gnt) state_d = ARB_CPU;
  end

  // Grants are held low while reset is asserted so every output reads 0.
  always_comb begin
    forced  = cpu_req && (starve_cnt_q == MAX_CNT);
    vga_gnt = rst && vga_req && !forced;
    cpu_gnt = rst && cpu_req && (forced || !vga_req);
  end

  always_comb begin
    starve_cnt_d = '0;
    if (cpu_req && !cpu_gnt) begin
      starve_cnt_d = (starve_cnt_q == MAX_CNT) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
    mem_en_d    = vga_gnt || cpu_gnt;
    mem_we_d    = cpu_gnt && cpu_we;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    own_issue   = OWN_NONE;
    if (cpu_gnt) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_we ? cpu_wdata : '0;
      own_issue   = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (vga_gnt) begin
      mem_addr_d  = vga_addr;
      own_issue   = OWN_VGA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  arb_rd_pipe #(.DEPTH(RD_LAT + 1)) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .own_in (own_issue),
    .own_out(own_head)
  );

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign vga_rvalid = (own_head == OWN_VGA);
  assign cpu_rvalid = (own_head == OWN_CPU);
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

  // The recorded owner and the issued command must always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(vga_gnt && cpu_gnt));
      assert ((state_q == ARB_IDLE) == !mem_en_q);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter against a transaction-level model.
module tb_vram_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_req, vga_gnt, vga_rvalid;
  logic [15:0] vga_addr;
  logic [7:0]  vga_rdata;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    bit         is_vga;
    logic [7:0] data;
  } rd_t;

  rd_t         pend[$];
  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  ram_rd;
  int          m_starve;
  int          cyc;
  bit          p_en, p_we, e_vga, e_cpu;
  logic [15:0] p_addr;
  logic [7:0]  p_wdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rd <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rd;

  vram_arbiter #(.AW(16), .DW(8), .MAX_WAIT(MAXW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_starve = 0;
    p_en = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    e_vga = 0; e_cpu = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vga_gnt"}, vga_gnt, 0);
    chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
    chk({tag, "_vga_rvalid"}, vga_rvalid, 0);
    chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_vga_rdata"}, vga_rdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One cycle: inputs are already driven; check against the model, advance it.
  task automatic step();
    bit forced, ev, ec, rv_v, rv_c;
    logic [7:0] rd;
    #1;
    forced = cpu_req && (m_starve == MAXW);
    ev = vga_req && !forced;
    ec = cpu_req && (forced || !vga_req);
    chk("vga_gnt", vga_gnt, ev);
    chk("cpu_gnt", cpu_gnt, ec);
    chk("one_gnt", vga_gnt && cpu_gnt, 0);
    chk("starve_cnt", dut.starve_cnt_q, m_starve);
    chk("mem_en", mem_en, p_en);
    if (p_en) begin
      chk("mem_we", mem_we, p_we);
      chk("mem_addr", mem_addr, p_addr);
      chk("mem_wdata", mem_wdata, p_wdata);
    end
    rv_v = 0; rv_c = 0; rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rv_v = pend[0].is_vga;
      rv_c = !pend[0].is_vga;
      rd   = pend[0].data;
      void'(pend.pop_front());
    end
    chk("vga_rvalid", vga_rvalid, rv_v);
    chk("cpu_rvalid", cpu_rvalid, rv_c);
    if (rv_v) chk("vga_rdata", vga_rdata, rd);
    if (rv_c) chk("cpu_rdata", cpu_rdata, rd);

    if (cpu_req && !ec) m_starve = (m_starve < MAXW) ? m_starve + 1 : MAXW;
    else                m_starve = 0;
    p_en    = ev || ec;
    p_we    = ec && cpu_we;
    p_addr  = ec ? cpu_addr : (ev ? vga_addr : '0);
    p_wdata = (ec && cpu_we) ? cpu_wdata : '0;
    if (ev) pend.push_back('{due: cyc + 2, is_vga: 1'b1, data: ref_mem[vga_addr]});
    if (ec) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else        pend.push_back('{due: cyc + 2, is_vga: 1'b0, data: ref_mem[cpu_addr]});
    end
    e_vga = ev;
    e_cpu = ec;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    vga_req = 0;
    cpu_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'((i * 37 + 11) ^ (i >> 8));
      ref_mem[i] = ram[i];
    end
    ram_rd = '0;
    rst = 1'b0;
    vga_req = 0; vga_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    cyc = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("rst_init");
    rst = 1'b1;

    // Reset arriving while a CPU read is in flight
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    step();
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    cpu_req = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    idle(4);

    // Lone write then read to the same address
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 8'hA5;
    step();
    cpu_we = 0; cpu_wdata = '0;
    step();
    cpu_req = 0;
    step();
    #1;
    chk("wr_rd_valid", cpu_rvalid, 1);
    chk("wr_rd_data", cpu_rdata, 8'hA5);
    step();
    idle(2);

    // Continuous contention: CPU forced through every MAX_WAIT+1 cycles
    vga_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    for (int k = 1; k <= 12; k++) begin
      vga_addr = 16'(k);
      #1;
      chk("contend_cpu", cpu_gnt, (k % 5) == 0);
      chk("contend_vga", vga_gnt, (k % 5) != 0);
      step();
    end
    idle(3);

    // VGA streaming: data returns in address order, two cycles after grant
    for (int j = 0; j < 10; j++) begin
      vga_req  = (j < 8);
      vga_addr = 16'(j);
      #1;
      if (j >= 2) begin
        chk("stream_rv", vga_rvalid, 1);
        chk("stream_data", vga_rdata, ram[j - 2]);
      end
      step();
    end
    idle(2);

    // Withdrawn CPU write under VGA load
    vga_req = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h5A;
    for (int j = 0; j < 5; j++) begin
      vga_addr = 16'(16'h0100 + j);
      if (j == 2) cpu_req = 0;
      #1;
      if (j == 3) chk("withdraw_starve", dut.starve_cnt_q, 0);
      chk("withdraw_we", mem_we, 0);
      step();
    end
    idle(3);
    chk("withdraw_mem", ram[16'h0040], ref_mem[16'h0040]);

    // Random traffic with requesters that hold requests until granted
    for (int n = 0; n < 10000; n++) begin
      if (!vga_req || e_vga) begin
        vga_req  = $urandom_range(1);
        vga_addr = 16'($urandom_range(63));
      end else if ($urandom_range(31) == 0) begin
        vga_req = 0;
      end
      if (!cpu_req || e_cpu) begin
        cpu_req   = $urandom_range(1);
        cpu_we    = $urandom_range(1);
        cpu_addr  = 16'($urandom_range(63));
        cpu_wdata = 8'($urandom);
      end else if ($urandom_range(31) == 0) begin
        cpu_req = 0;
      end
      step();
    end
    idle(4);
    chk("drain_empty", pend.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
